// File: rtl/slscp_step_ctrl.sv
// slscp_step_ctrl: step sequencer for the sLiSCP-light permutation datapath.
// Each step loads round/step constants, runs both SB instances for NROUNDS
// cycles, then strobes the mix. All outputs are registered.
module slscp_step_ctrl #(
    parameter int unsigned NSTEPS  = 18,
    parameter int unsigned NROUNDS = 8,
    parameter int unsigned STEP_W  = 5,
    parameter int unsigned RCW     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              rnd_done_a,
    input  logic              rnd_done_b,
    output logic [STEP_W-1:0] const_addr,
    input  logic [RCW-1:0]    rc_a_in,
    input  logic [RCW-1:0]    rc_b_in,
    input  logic [RCW-1:0]    sc_a_in,
    input  logic [RCW-1:0]    sc_b_in,
    output logic [RCW-1:0]    rc_a,
    output logic [RCW-1:0]    rc_b,
    output logic [RCW-1:0]    sc_a,
    output logic [RCW-1:0]    sc_b,
    output logic              en_rnd_ctr,
    output logic              mix_en,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              err
);

    localparam int unsigned RW = (NROUNDS > 1) ? $clog2(NROUNDS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_MIX,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [STEP_W-1:0]   r_step_ctr;
    logic [RW-1:0]       r_rnd_ctr;
    logic                r_abort_pend;
    logic [RCW-1:0]      r_rc_a, r_rc_b, r_sc_a, r_sc_b;
    logic                r_en_rnd_ctr, r_mix_en, r_ready, r_busy;
    logic                r_done, r_aborted, r_err;

    logic                w_last_rnd;
    logic                w_last_step;

    assign w_last_rnd  = (r_rnd_ctr == RW'(NROUNDS - 1));
    assign w_last_step = (r_step_ctr == STEP_W'(NSTEPS - 1));

    // Sequencer FSM with registered outputs; outputs are set on the edge that
    // enters the state they belong to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_step_ctr   <= '0;
            r_rnd_ctr    <= '0;
            r_abort_pend <= 1'b0;
            r_rc_a       <= '0;
            r_rc_b       <= '0;
            r_sc_a       <= '0;
            r_sc_b       <= '0;
            r_en_rnd_ctr <= 1'b0;
            r_mix_en     <= 1'b0;
            r_ready      <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_mix_en  <= 1'b0;

            // Both SB round counters must signal completion exactly on the last round.
            if (r_state == S_ROUND &&
                (rnd_done_a != w_last_rnd || rnd_done_b != w_last_rnd)) begin
                r_err <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_state    <= S_LOAD;
                        r_step_ctr <= '0;
                        r_ready    <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end

                S_LOAD: begin
                    r_rc_a <= rc_a_in;
                    r_rc_b <= rc_b_in;
                    r_sc_a <= sc_a_in;
                    r_sc_b <= sc_b_in;
                    if (abort) begin
                        r_state      <= S_IDLE;
                        r_aborted    <= 1'b1;
                        r_ready      <= 1'b1;
                        r_busy       <= 1'b0;
                        r_step_ctr   <= '0;
                        r_abort_pend <= 1'b0;
                    end else begin
                        r_state      <= S_ROUND;
                        r_rnd_ctr    <= '0;
                        r_en_rnd_ctr <= 1'b1;
                        r_abort_pend <= 1'b0;
                    end
                end

                // Abort is deferred until the burst ends so the SB counters land on 0.
                S_ROUND: begin
                    if (abort) begin
                        r_abort_pend <= 1'b1;
                    end
                    if (w_last_rnd) begin
                        r_rnd_ctr    <= '0;
                        r_en_rnd_ctr <= 1'b0;
                        if (r_abort_pend || abort) begin
                            r_state      <= S_IDLE;
                            r_aborted    <= 1'b1;
                            r_ready      <= 1'b1;
                            r_busy       <= 1'b0;
                            r_step_ctr   <= '0;
                            r_abort_pend <= 1'b0;
                        end else begin
                            r_state  <= S_MIX;
                            r_mix_en <= 1'b1;
                        end
                    end else begin
                        r_rnd_ctr <= r_rnd_ctr + 1'b1;
                    end
                end

                S_MIX: begin
                    if (abort) begin
                        r_state    <= S_IDLE;
                        r_aborted  <= 1'b1;
                        r_ready    <= 1'b1;
                        r_busy     <= 1'b0;
                        r_step_ctr <= '0;
                    end else if (w_last_step) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state    <= S_LOAD;
                        r_step_ctr <= r_step_ctr + 1'b1;
                    end
                end

                S_DONE: begin
                    r_state    <= S_IDLE;
                    r_step_ctr <= '0;
                    r_ready    <= 1'b1;
                end

                default: begin
                    r_state      <= S_IDLE;
                    r_step_ctr   <= '0;
                    r_rnd_ctr    <= '0;
                    r_abort_pend <= 1'b0;
                    r_en_rnd_ctr <= 1'b0;
                    r_ready      <= 1'b1;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign const_addr = r_step_ctr;
    assign rc_a       = r_rc_a;
    assign rc_b       = r_rc_b;
    assign sc_a       = r_sc_a;
    assign sc_b       = r_sc_b;
    assign en_rnd_ctr = r_en_rnd_ctr;
    assign mix_en     = r_mix_en;
    assign ready      = r_ready;
    assign busy       = r_busy;
    assign done       = r_done;
    assign aborted    = r_aborted;
    assign err        = r_err;

endmodule
